multicycle_controller: RTL and testbench

Control unit for the multi-cycle ARM datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. Combinational decode of the instruction register drives every datapath select and write-enable; condition-code evaluation against the registered ALU flags gates the architectural writes. It sits directly upstream of the datapath, consuming `Instr` and `ALUFlags` and producing all of the datapath's control inputs.

---
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for the multi-cycle ARM datapath.
// Optional BL link write: define CTRL_BL_EN (default build treats BL as B).
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        SetFlags,
  output logic        CarryIN,
  output logic        Shift_ctrl,
  output logic        ALUSrcA,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  BL_ctrl,
  output logic [3:0]  ALUControl,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0100;

  state_e state_q, state_d;

  logic [1:0] op;
  logic [3:0] cmd;
  logic [3:0] cond;
  logic       imm_f;
  logic       ld_f;
  logic       rd_pc;
  logic       z_f, n_f, c_f, v_f;
  logic       cond_ex;

  assign op    = Instr[27:26];
  assign imm_f = Instr[25];
  assign cmd   = Instr[24:21];
  assign ld_f  = Instr[20];
  assign rd_pc = (Instr[15:12] == 4'hF);
  assign cond  = Instr[31:28];
  assign z_f   = ALUFlags[3];
  assign n_f   = ALUFlags[2];
  assign c_f   = ALUFlags[1];
  assign v_f   = ALUFlags[0];
  assign state = state_q;

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // ARM condition-code evaluation against the registered flags.
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next-state and Moore control decode.
  always_comb begin
    state_d    = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    SetFlags   = 1'b0;
    CarryIN    = 1'b0;
    Shift_ctrl = 1'b0;
    ALUSrcA    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    BL_ctrl    = 2'b00;
    ALUControl = 4'b0000;
    RegSrc     = {(op == 2'b01) & ~ld_f, (op == 2'b10)};
    ImmSrc     = (op == 2'b11) ? 2'b00 : op;

    case (state_q)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b10;
        unique case (op)
          2'b00:   state_d = imm_f ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        state_d    = ld_f ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & rd_pc;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      EXECR, EXECI: begin
        ALUSrcB    = 2'b11;
        ALUControl = cmd;
        SetFlags   = ld_f & cond_ex;
        Shift_ctrl = (state_q == EXECI);
        CarryIN    = (cmd inside {4'b0101, 4'b0110, 4'b0111}) & c_f;
        state_d    = ALUWB;
      end
      ALUWB: begin
        RegWrite = cond_ex & ~(cmd[3:2] == 2'b10);
        PCWrite  = cond_ex & rd_pc;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b10;
        PCWrite    = cond_ex;
`ifdef CTRL_BL_EN
        if (Instr[24]) begin
          BL_ctrl  = 2'b11;
          RegWrite = cond_ex;
        end
`endif
      end
      default: state_d = FETCH;
    endcase

    if (!reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      SetFlags = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multi-cycle control FSM.
// Instruction sequences with hand-derived state and control expectations.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic        SetFlags, CarryIN, Shift_ctrl, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, BL_ctrl;
  logic [3:0]  ALUControl;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .SetFlags   (SetFlags),
    .CarryIN    (CarryIN),
    .Shift_ctrl (Shift_ctrl),
    .ALUSrcA    (ALUSrcA),
    .ResultSrc  (ResultSrc),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .BL_ctrl    (BL_ctrl),
    .ALUControl (ALUControl),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; Instr = 32'h0; ALUFlags = 4'h0;
    step(); step();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL rst_state got %0d exp 0", state);
    end
    checks++;
    if ({PCWrite, IRWrite} !== 2'b00) begin
      errors++; $display("FAIL rst_we got %b exp 00", {PCWrite, IRWrite});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({PCWrite, IRWrite, ALUControl} !== 6'b11_0100) begin
      errors++; $display("FAIL fetch_ctl got %b exp 110100", {PCWrite, IRWrite, ALUControl});
    end
  endtask

  task automatic test_add();
    Instr = 32'hE0821003; ALUFlags = 4'h0;
    step();
    checks++;
    if (state !== 4'd1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL add_dec got st=%0d rw=%b exp st=1 rw=0", state, RegWrite);
    end
    step();
    checks++;
    if (state !== 4'd6 || ALUControl !== 4'b0100 || RegWrite !== 1'b0 || Shift_ctrl !== 1'b0) begin
      errors++; $display("FAIL add_exec got st=%0d alu=%b rw=%b sh=%b exp 6 0100 0 0", state, ALUControl, RegWrite, Shift_ctrl);
    end
    step();
    checks++;
    if (state !== 4'd8 || RegWrite !== 1'b1 || PCWrite !== 1'b0) begin
      errors++; $display("FAIL add_wb got st=%0d rw=%b pw=%b exp 8 1 0", state, RegWrite, PCWrite);
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL add_end got %0d exp 0", state);
    end
  endtask

  task automatic test_ldr();
    Instr = 32'hE5910004;
    step(); step();
    checks++;
    if (state !== 4'd2 || ImmSrc !== 2'b01 || ALUSrcB !== 2'b01 || RegSrc !== 2'b00) begin
      errors++; $display("FAIL ldr_adr got st=%0d imm=%b srcb=%b rs=%b exp 2 01 01 00", state, ImmSrc, ALUSrcB, RegSrc);
    end
    step();
    checks++;
    if (state !== 4'd3 || AdrSrc !== 1'b1) begin
      errors++; $display("FAIL ldr_rd got st=%0d adr=%b exp 3 1", state, AdrSrc);
    end
    step();
    checks++;
    if (state !== 4'd4 || ResultSrc !== 2'b01 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL ldr_wb got st=%0d res=%b rw=%b exp 4 01 1", state, ResultSrc, RegWrite);
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL ldr_end got %0d exp 0", state);
    end
  endtask

  task automatic test_str();
    Instr = 32'hE5810004;
    step(); step();
    checks++;
    if (state !== 4'd2 || RegSrc !== 2'b10) begin
      errors++; $display("FAIL str_adr got st=%0d rs=%b exp 2 10", state, RegSrc);
    end
    step();
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1 || AdrSrc !== 1'b1) begin
      errors++; $display("FAIL str_wr got st=%0d mw=%b adr=%b exp 5 1 1", state, MemWrite, AdrSrc);
    end
    step();
    Instr = 32'h15810004; ALUFlags = 4'b1000;
    step(); step(); step();
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b0) begin
      errors++; $display("FAIL strne_wr got st=%0d mw=%b exp 5 0", state, MemWrite);
    end
    step();
    ALUFlags = 4'h0;
  endtask

  task automatic test_cmp();
    Instr = 32'hE1510002;
    step(); step();
    checks++;
    if (state !== 4'd6 || SetFlags !== 1'b1 || ALUControl !== 4'b1010) begin
      errors++; $display("FAIL cmp_exec got st=%0d sf=%b alu=%b exp 6 1 1010", state, SetFlags, ALUControl);
    end
    step();
    checks++;
    if (state !== 4'd8 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL cmp_wb got st=%0d rw=%b exp 8 0", state, RegWrite);
    end
    step();
  endtask

  task automatic test_alu_misc();
    Instr = 32'hE0A21003; ALUFlags = 4'b0010;
    step(); step();
    checks++;
    if (CarryIN !== 1'b1 || ALUControl !== 4'b0101) begin
      errors++; $display("FAIL adc_cin got cin=%b alu=%b exp 1 0101", CarryIN, ALUControl);
    end
    step(); step();
    Instr = 32'hE282F003; ALUFlags = 4'b0010;
    step(); step();
    checks++;
    if (state !== 4'd7 || Shift_ctrl !== 1'b1 || CarryIN !== 1'b0) begin
      errors++; $display("FAIL addi_exec got st=%0d sh=%b cin=%b exp 7 1 0", state, Shift_ctrl, CarryIN);
    end
    step();
    checks++;
    if (PCWrite !== 1'b1 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL rd15_wb got pw=%b rw=%b exp 1 1", PCWrite, RegWrite);
    end
    step();
    ALUFlags = 4'h0;
  endtask

  task automatic test_branch();
    Instr = 32'h0A000002; ALUFlags = 4'b0000;
    step(); step();
    checks++;
    if (state !== 4'd9 || PCWrite !== 1'b0 || RegSrc !== 2'b01 || ImmSrc !== 2'b10) begin
      errors++; $display("FAIL beq_nt got st=%0d pw=%b rs=%b imm=%b exp 9 0 01 10", state, PCWrite, RegSrc, ImmSrc);
    end
    step();
    ALUFlags = 4'b1000;
    step(); step();
    checks++;
    if (state !== 4'd9 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL beq_t got st=%0d pw=%b exp 9 1", state, PCWrite);
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL b_end got %0d exp 0", state);
    end
    ALUFlags = 4'h0;
  endtask

  task automatic test_bl();
    Instr = 32'hEB000001;
    step(); step();
`ifdef CTRL_BL_EN
    checks++;
    if (BL_ctrl !== 2'b11 || RegWrite !== 1'b1 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL bl_link got bl=%b rw=%b pw=%b exp 11 1 1", BL_ctrl, RegWrite, PCWrite);
    end
`else
    checks++;
    if (BL_ctrl !== 2'b00 || RegWrite !== 1'b0 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL bl_nolink got bl=%b rw=%b pw=%b exp 00 0 1", BL_ctrl, RegWrite, PCWrite);
    end
`endif
    step();
  endtask

  task automatic test_unsupported();
    Instr = 32'hEC000000;
    step();
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL nop_dec got %0d exp 1", state);
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL nop_end got %0d exp 0", state);
    end
  endtask

  task automatic test_reset_mid();
    Instr = 32'hE5910004;
    step(); step(); step();
    checks++;
    if (state !== 4'd3) begin
      errors++; $display("FAIL mid_pre got %0d exp 3", state);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
        errors++; $display("FAIL mid_rst%0d got st=%0d mw=%b rw=%b ir=%b pw=%b exp 0 0 0 0 0", i, state, MemWrite, RegWrite, IRWrite, PCWrite);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || IRWrite !== 1'b1) begin
      errors++; $display("FAIL mid_rel got st=%0d ir=%b exp 0 1", state, IRWrite);
    end
    step();
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL mid_next got %0d exp 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_str();
    test_cmp();
    test_alu_misc();
    test_branch();
    test_bl();
    test_unsupported();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
